// File: rtl/laplace_stream.sv
// laplace_stream: streaming 5-point Laplacian filter (4e - b - d - f - h).
// Accepts a raster-scan pixel stream, keeps the two previous rows in line
// buffers and emits one result per interior pixel through a single output
// register with a valid/ready handshake.
//
// Optional build macro: LAPLACE_ABS_SAT_EN
//   defined     -> out_pix[PIX_W-1:0] = min(|result|, 2^PIX_W-1), top 3 bits 0
//   not defined -> out_pix = raw two's complement result (PIX_W+3 bits)
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_pix/in_sof         input pixel and start-of-frame marker
//   in_valid/in_ready     input handshake (in_ready = !out_valid || out_ready)
//   out_pix/out_eof       registered result and last-result-of-frame marker
//   out_valid/out_ready   output handshake
module laplace_stream #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   in_pix,
  input  logic               in_sof,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [PIX_W+2:0]   out_pix,
  output logic               out_eof,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned OUT_W = PIX_W + 3;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2 (not reset).
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PIX_W-1:0] top_d1_q, top_d1_d;
  logic [PIX_W-1:0] mid_d1_q, mid_d1_d;
  logic [PIX_W-1:0] mid_d2_q, mid_d2_d;
  logic [PIX_W-1:0] bot_d1_q, bot_d1_d;
  logic [OUT_W-1:0] out_pix_q, out_pix_d;
  logic             out_eof_q, out_eof_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [COL_W-1:0] col_cur;
  logic [ROW_W-1:0] row_cur;
  logic             col_end;
  logic             row_end;
  logic             gen;
  logic [PIX_W-1:0] top;
  logic [PIX_W-1:0] mid;
  logic [OUT_W-1:0] result;
  logic [OUT_W-1:0] out_val;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Position of the pixel being offered; in_sof forces it to (0,0).
  assign col_cur = in_sof ? '0 : col_q;
  assign row_cur = in_sof ? '0 : row_q;
  assign col_end = (col_cur == COL_W'(IMG_W - 1));
  assign row_end = (row_cur == ROW_W'(IMG_H - 1));
  assign gen     = (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));

  assign top = lb2[col_cur];
  assign mid = lb1[col_cur];

  // Kernel centred at (r-1,c-1); unsigned wraparound equals signed result.
  assign result = (OUT_W'(mid_d1_q) << 2) - OUT_W'(top_d1_q) - OUT_W'(mid_d2_q)
                - OUT_W'(mid) - OUT_W'(bot_d1_q);

`ifdef LAPLACE_ABS_SAT_EN
  localparam logic [OUT_W-1:0] SAT_MAX = {3'b000, {PIX_W{1'b1}}};
  logic [OUT_W-1:0] mag;
  assign mag     = result[OUT_W-1] ? (OUT_W'(0) - result) : result;
  assign out_val = (mag > SAT_MAX) ? SAT_MAX : mag;
`else
  assign out_val = result;
`endif

  // Next-state: counters, window and output register.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    top_d1_d    = top_d1_q;
    mid_d1_d    = mid_d1_q;
    mid_d2_d    = mid_d2_q;
    bot_d1_d    = bot_d1_q;
    out_pix_d   = out_pix_q;
    out_eof_d   = out_eof_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_cur + ROW_W'(1);
      end else begin
        col_d = col_cur + COL_W'(1);
        row_d = row_cur;
      end
      top_d1_d = top;
      mid_d1_d = mid;
      mid_d2_d = mid_d1_q;
      bot_d1_d = in_pix;
      if (gen) begin
        out_valid_d = 1'b1;
        out_pix_d   = out_val;
        out_eof_d   = row_end && col_end;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      top_d1_q    <= '0;
      mid_d1_q    <= '0;
      mid_d2_q    <= '0;
      bot_d1_q    <= '0;
      out_pix_q   <= '0;
      out_eof_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      top_d1_q    <= top_d1_d;
      mid_d1_q    <= mid_d1_d;
      mid_d2_q    <= mid_d2_d;
      bot_d1_q    <= bot_d1_d;
      out_pix_q   <= out_pix_d;
      out_eof_q   <= out_eof_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Line buffer shift, read-before-write at the accepted column.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col_cur] <= mid;
      lb1[col_cur] <= in_pix;
    end
  end

  assign out_pix   = out_pix_q;
  assign out_eof   = out_eof_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_laplace_stream.sv
// Self-checking bench for laplace_stream (PIX_W=8, IMG_W=5, IMG_H=4).
module tb_laplace_stream;

  localparam int PIX_W = 8;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int OUT_W = PIX_W + 3;

  typedef struct {
    logic [PIX_W-1:0] pix;
    logic             sof;
  } item_t;

  typedef struct {
    logic [OUT_W-1:0] pix;
    logic             eof;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PIX_W-1:0] in_pix = '0;
  logic             in_sof = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] out_pix;
  logic             out_eof;
  logic             out_valid;
  logic             out_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int stall_err = 0;
  int ready_err = 0;

  int    img [IMG_H][IMG_W];
  item_t stim [$];
  res_t  got [$];
  res_t  exp_q [$];

  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] held_pix;
  logic             held_eof;

  laplace_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n), .in_pix(in_pix), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready), .out_pix(out_pix),
    .out_eof(out_eof), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Collector: records completed output transfers and handshake violations.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (in_ready !== (!out_valid || out_ready)) ready_err++;
      if (prev_stall && (out_valid !== 1'b1 || out_pix !== held_pix || out_eof !== held_eof))
        stall_err++;
      if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back('{pix: out_pix, eof: out_eof});
      prev_stall = (out_valid === 1'b1) && !out_ready;
      held_pix   = out_pix;
      held_eof   = out_eof;
    end
  end

  // Reference: direct 5-point Laplacian over the stored image.
  task automatic model_frame();
    int v, m;
    res_t e;
    for (int r = 1; r <= IMG_H - 2; r++)
      for (int c = 1; c <= IMG_W - 2; c++) begin
        v = 4 * img[r][c] - img[r-1][c] - img[r+1][c] - img[r][c-1] - img[r][c+1];
`ifdef LAPLACE_ABS_SAT_EN
        m = (v < 0) ? -v : v;
        if (m > 255) m = 255;
        e.pix = OUT_W'(m);
`else
        m = v;
        e.pix = OUT_W'(m);
`endif
        e.eof = (r == IMG_H - 2) && (c == IMG_W - 2);
        exp_q.push_back(e);
      end
  endtask

  task automatic fill_img(input int mode);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        case (mode)
          0: img[r][c] = 255;
          1: img[r][c] = (r == 1 && c == 2) ? 255 : 0;
          2: img[r][c] = (r == 2 && c == 2) ? 0 : 255;
          3: img[r][c] = r * 5 + c;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  task automatic queue_img(input logic first_sof);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        stim.push_back('{pix: PIX_W'(img[r][c]), sof: first_sof && r == 0 && c == 0});
  endtask

  // Drives stim; inputs change 1 time unit after the rising edge.
  task automatic send(input bit bp, output int cycles);
    int idx = 0;
    cycles = 0;
    while (idx < stim.size()) begin
      @(posedge clk); #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = 1'b1;
      in_pix    = stim[idx].pix;
      in_sof    = stim[idx].sof;
      cycles++;
      @(negedge clk);
      if (in_ready) idx++;
      if (cycles > 4000) begin
        errors++;
        $display("FAIL send_timeout got=%0d accepted required=%0d", idx, stim.size());
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    stim.delete();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b required=0", out_valid); end
    checks++; if (out_pix !== '0) begin errors++; $display("FAIL reset_pix got=%0d required=0", out_pix); end
    checks++; if (out_eof !== 1'b0) begin errors++; $display("FAIL reset_eof got=%b required=0", out_eof); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_patterns();
    int cyc;
    for (int mode = 0; mode < 3; mode++) begin
      got.delete(); exp_q.delete();
      fill_img(mode); queue_img(1'b1); model_frame();
      send(1'b0, cyc); drain();
      checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL pattern%0d_count got=%0d required=%0d", mode, got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got[i].pix !== exp_q[i].pix || got[i].eof !== exp_q[i].eof) begin
          errors++;
          $display("FAIL pattern%0d[%0d] got pix=%0d eof=%b required pix=%0d eof=%b", mode, i,
                   $signed(got[i].pix), got[i].eof, $signed(exp_q[i].pix), exp_q[i].eof);
        end
      end
    end
  endtask

  task automatic test_throughput();
    int cyc;
    got.delete(); exp_q.delete();
    fill_img(4); queue_img(1'b0); model_frame();
    send(1'b0, cyc); drain();
    checks++; if (cyc != IMG_W * IMG_H) begin errors++; $display("FAIL throughput_cycles got=%0d required=%0d", cyc, IMG_W * IMG_H); end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL throughput_count got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i].pix !== exp_q[i].pix || got[i].eof !== exp_q[i].eof) begin
        errors++;
        $display("FAIL throughput[%0d] got pix=%0d eof=%b required pix=%0d eof=%b", i,
                 $signed(got[i].pix), got[i].eof, $signed(exp_q[i].pix), exp_q[i].eof);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    for (int k = 0; k < 2; k++) begin
      got.delete(); exp_q.delete(); stall_err = 0; ready_err = 0;
      fill_img(k == 0 ? 3 : 4); queue_img(1'b0); model_frame();
      send(1'b1, cyc); drain();
      checks++; if (stall_err != 0) begin errors++; $display("FAIL bp%0d_stall_stable got=%0d violations required=0", k, stall_err); end
      checks++; if (ready_err != 0) begin errors++; $display("FAIL bp%0d_in_ready got=%0d violations required=0", k, ready_err); end
      checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL bp%0d_count got=%0d required=%0d", k, got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got[i].pix !== exp_q[i].pix || got[i].eof !== exp_q[i].eof) begin
          errors++;
          $display("FAIL bp%0d[%0d] got pix=%0d eof=%b required pix=%0d eof=%b", k, i,
                   $signed(got[i].pix), got[i].eof, $signed(exp_q[i].pix), exp_q[i].eof);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    got.delete(); exp_q.delete();
    for (int f = 0; f < 2; f++) begin
      fill_img(4); queue_img(1'b0); model_frame();
    end
    send(1'b0, cyc); drain();
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i].pix !== exp_q[i].pix || got[i].eof !== exp_q[i].eof) begin
        errors++;
        $display("FAIL b2b[%0d] got pix=%0d eof=%b required pix=%0d eof=%b", i,
                 $signed(got[i].pix), got[i].eof, $signed(exp_q[i].pix), exp_q[i].eof);
      end
    end
  endtask

  task automatic test_sof_mid();
    int cyc;
    got.delete(); exp_q.delete();
    for (int i = 0; i < 7; i++) stim.push_back('{pix: PIX_W'($urandom_range(0, 255)), sof: 1'b0});
    fill_img(4); queue_img(1'b1); model_frame();
    send(1'b0, cyc); drain();
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL sof_count got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i].pix !== exp_q[i].pix || got[i].eof !== exp_q[i].eof) begin
        errors++;
        $display("FAIL sof[%0d] got pix=%0d eof=%b required pix=%0d eof=%b", i,
                 $signed(got[i].pix), got[i].eof, $signed(exp_q[i].pix), exp_q[i].eof);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    // 13 pixels reach (2,2), which generates a result left stalled in the output register.
    for (int i = 0; i < 13; i++) stim.push_back('{pix: PIX_W'($urandom_range(1, 255)), sof: 1'b0});
    send(1'b0, cyc);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got=%b required=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b required=0", out_valid); end
    checks++; if (out_pix !== '0) begin errors++; $display("FAIL rstmid_pix got=%0d required=0", out_pix); end
    checks++; if (out_eof !== 1'b0) begin errors++; $display("FAIL rstmid_eof got=%b required=0", out_eof); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b required=1", in_ready); end
    @(posedge clk); #3 rst_n = 1'b1;
    out_ready = 1'b1;
    got.delete(); exp_q.delete();
    fill_img(4); queue_img(1'b0); model_frame();
    send(1'b0, cyc); drain();
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i].pix !== exp_q[i].pix || got[i].eof !== exp_q[i].eof) begin
        errors++;
        $display("FAIL rstmid[%0d] got pix=%0d eof=%b required pix=%0d eof=%b", i,
                 $signed(got[i].pix), got[i].eof, $signed(exp_q[i].pix), exp_q[i].eof);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    #2 rst_n = 1'b1;
    test_patterns();
    test_throughput();
    test_backpressure();
    test_back_to_back();
    test_sof_mid();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
